// File: rtl/bluetooth_decoder.sv
// rtl/bluetooth_decoder.sv - BLE UART reply parser: payload extraction and OK/ERROR/timeout classification
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        arm the decoder for one reply (sampled only while idle)
//   rx_byte      received ASCII byte
//   rx_valid     rx_byte valid this cycle (one strobe per byte)
//   output_data  payload, first byte in [7:0]; unused bytes zero
//   data_len     number of valid payload bytes, 0..4
//   done         1 = idle / result valid, 0 = transaction in progress
//   ok           reply terminated by line "OK"
//   error        reply terminated by line "ERROR"
//   timeout      transaction aborted by inactivity
//   overflow     payload line longer than 4 bytes, or a second payload line
module bluetooth_decoder #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [31:0] output_data,
  output logic [2:0]  data_len,
  output logic        done,
  output logic        ok,
  output logic        error,
  output logic        timeout,
  output logic        overflow
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state, state_next;

  // Line buffer holds the first 5 bytes of the current line; byte i at [8*i +: 8].
  logic [39:0]     line_buf;
  logic [2:0]      line_len;
  logic            got_payload;
  logic [TO_W-1:0] to_cnt;

  logic        byte_in;
  logic        is_cr;
  logic        is_lf;
  logic        line_is_ok;
  logic        line_is_err;
  logic        to_expire;
  logic        terminate;
  logic [2:0]  len_clip;
  logic [31:0] payload;

  always_comb begin
    byte_in     = (state == BUSY) && rx_valid;
    is_cr       = (rx_byte == 8'h0D);
    is_lf       = (rx_byte == 8'h0A);
    // "OK": 'O'=0x4F first, 'K'=0x4B second
    line_is_ok  = (line_len == 3'd2) && (line_buf[15:0] == 16'h4B4F);
    // "ERROR" stored first-byte-lowest
    line_is_err = (line_len == 3'd5) && (line_buf == 40'h52_4F_52_52_45);
    to_expire   = (state == BUSY) && !rx_valid &&
                  (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    terminate   = byte_in && is_lf && (line_is_ok || line_is_err);

    len_clip = (line_len > 3'd4) ? 3'd4 : line_len;
    // Mask explicitly so bytes beyond the line length are always zero.
    case (len_clip)
      3'd0:    payload = 32'h0;
      3'd1:    payload = {24'h0, line_buf[7:0]};
      3'd2:    payload = {16'h0, line_buf[15:0]};
      3'd3:    payload = {8'h0,  line_buf[23:0]};
      default: payload = line_buf[31:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE: begin
        done = 1'b1;
        if (start) state_next = BUSY;
      end
      BUSY: begin
        if (terminate || to_expire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      output_data <= 32'h0;
      data_len    <= 3'd0;
      ok          <= 1'b0;
      error       <= 1'b0;
      timeout     <= 1'b0;
      overflow    <= 1'b0;
      line_buf    <= 40'h0;
      line_len    <= 3'd0;
      got_payload <= 1'b0;
      to_cnt      <= '0;
    end else if (state == IDLE) begin
      // Any byte arriving alongside start is dropped.
      if (start) begin
        output_data <= 32'h0;
        data_len    <= 3'd0;
        ok          <= 1'b0;
        error       <= 1'b0;
        timeout     <= 1'b0;
        overflow    <= 1'b0;
        line_buf    <= 40'h0;
        line_len    <= 3'd0;
        got_payload <= 1'b0;
        to_cnt      <= '0;
      end
    end else if (byte_in) begin
      to_cnt <= '0;
      if (is_lf) begin
        line_len <= 3'd0;
        line_buf <= 40'h0;
        if (line_len != 3'd0) begin
          if (line_is_ok) begin
            ok <= 1'b1;
          end else if (line_is_err) begin
            error <= 1'b1;
          end else if (!got_payload) begin
            output_data <= payload;
            data_len    <= len_clip;
            got_payload <= 1'b1;
            if (line_len > 3'd4) overflow <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end else if (!is_cr) begin
        if (line_len < 3'd5) line_buf[{line_len, 3'b000} +: 8] <= rx_byte;
        if (line_len != 3'd7) line_len <= line_len + 3'd1;
      end
    end else if (to_expire) begin
      timeout <= 1'b1;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bluetooth_decoder.sv
// tb/tb_bluetooth_decoder.sv - directed self-checking bench for bluetooth_decoder
module tb_bluetooth_decoder;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [31:0] output_data;
  logic [2:0]  data_len;
  logic        done;
  logic        ok;
  logic        error;
  logic        timeout;
  logic        overflow;

  int vectors;
  int miscompares;

  bluetooth_decoder #(
    .TIMEOUT_CYCLES(16),
    .TO_W(5)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .output_data(output_data),
    .data_len(data_len),
    .done(done),
    .ok(ok),
    .error(error),
    .timeout(timeout),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    #12;
    vectors++;
    if ({done, ok, error, timeout, overflow} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_flags got=%b exp=10000", {done, ok, error, timeout, overflow});
    end
    vectors++;
    if (output_data !== 32'h0 || data_len !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_data got=%h/%0d exp=0/0", output_data, data_len);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_payload();
    do_start();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL payload_busy done=%b exp=0", done);
    end
    send_str("ABCD\r\nOK\r");
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL payload_pre_lf done=%b exp=0", done);
    end
    send_byte(8'h0A);
    vectors++;
    if ({done, ok, error, overflow, timeout} !== 5'b11000) begin
      miscompares++;
      $display("FAIL payload_flags got=%b exp=11000", {done, ok, error, overflow, timeout});
    end
    vectors++;
    if (output_data !== 32'h44434241 || data_len !== 3'd4) begin
      miscompares++;
      $display("FAIL payload_data got=%h/%0d exp=44434241/4", output_data, data_len);
    end
  endtask

  task automatic test_empty();
    do_start();
    send_str("OK\r\n");
    vectors++;
    if ({done, ok, error} !== 3'b110 || output_data !== 32'h0 || data_len !== 3'd0) begin
      miscompares++;
      $display("FAIL empty got=%b %h/%0d exp=110 0/0", {done, ok, error}, output_data, data_len);
    end
  endtask

  task automatic test_error();
    do_start();
    send_str("ERROR\r\n");
    vectors++;
    if ({done, ok, error, overflow} !== 4'b1010 || data_len !== 3'd0) begin
      miscompares++;
      $display("FAIL error got=%b len=%0d exp=1010 len=0", {done, ok, error, overflow}, data_len);
    end
  endtask

  task automatic test_long_payload();
    do_start();
    send_str("HELLOWORLD\r\nOK\r\n");
    vectors++;
    if (output_data !== 32'h4C4C4548 || data_len !== 3'd4) begin
      miscompares++;
      $display("FAIL long_data got=%h/%0d exp=4C4C4548/4", output_data, data_len);
    end
    vectors++;
    if ({done, ok, overflow} !== 3'b111) begin
      miscompares++;
      $display("FAIL long_flags got=%b exp=111", {done, ok, overflow});
    end
  endtask

  task automatic test_two_lines();
    do_start();
    send_str("AB\r\nCD\r\nOK\r\n");
    vectors++;
    if (output_data !== 32'h00004241 || data_len !== 3'd2) begin
      miscompares++;
      $display("FAIL two_lines_data got=%h/%0d exp=00004241/2", output_data, data_len);
    end
    vectors++;
    if ({done, ok, overflow} !== 3'b111) begin
      miscompares++;
      $display("FAIL two_lines_flags got=%b exp=111", {done, ok, overflow});
    end
  endtask

  task automatic test_timeout();
    do_start();
    send_str("AB");
    for (int i = 0; i < 15; i++) tick();
    vectors++;
    if (done !== 1'b0 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early done=%b timeout=%b exp=0/0", done, timeout);
    end
    tick();
    vectors++;
    if ({done, timeout, ok, error} !== 4'b1100 || data_len !== 3'd0) begin
      miscompares++;
      $display("FAIL timeout_fire got=%b len=%0d exp=1100 len=0", {done, timeout, ok, error}, data_len);
    end
    send_str("XY\r\nOK\r\n");
    vectors++;
    if ({done, timeout, ok, error, overflow} !== 5'b11000 || output_data !== 32'h0 || data_len !== 3'd0) begin
      miscompares++;
      $display("FAIL timeout_idle_bytes got=%b %h/%0d exp=11000 0/0",
               {done, timeout, ok, error, overflow}, output_data, data_len);
    end
  endtask

  task automatic test_reset_midline();
    do_start();
    send_str("XY\r\n");
    do_start();
    vectors++;
    if (done !== 1'b0 || output_data !== 32'h00005958 || data_len !== 3'd2) begin
      miscompares++;
      $display("FAIL ignored_start got=%b %h/%0d exp=0 00005958/2", done, output_data, data_len);
    end
    send_byte("C");
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({done, ok, error, timeout, overflow} !== 5'b10000 || output_data !== 32'h0 || data_len !== 3'd0) begin
      miscompares++;
      $display("FAIL async_reset got=%b %h/%0d exp=10000 0/0",
               {done, ok, error, timeout, overflow}, output_data, data_len);
    end
    reset_n = 1'b1;
    tick();
    do_start();
    send_str("Z\r\nOK\r\n");
    vectors++;
    if ({done, ok, error, overflow} !== 4'b1100 || output_data !== 32'h0000005A || data_len !== 3'd1) begin
      miscompares++;
      $display("FAIL after_reset got=%b %h/%0d exp=1100 0000005A/1",
               {done, ok, error, overflow}, output_data, data_len);
    end
  endtask

  task automatic test_back_to_back();
    // Byte presented with start is dropped; "Q" must not reach the payload.
    start    = 1'b1;
    rx_byte  = "Q";
    rx_valid = 1'b1;
    tick();
    start    = 1'b0;
    rx_valid = 1'b0;
    send_str("W\r\nOK\r\n");
    vectors++;
    if (output_data !== 32'h00000057 || data_len !== 3'd1 || ok !== 1'b1) begin
      miscompares++;
      $display("FAIL start_byte_drop got=%h/%0d ok=%b exp=00000057/1 ok=1", output_data, data_len, ok);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_payload();
    test_empty();
    test_error();
    test_long_payload();
    test_two_lines();
    test_timeout();
    test_reset_midline();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bluetooth_decoder.md
Name: bluetooth_decoder

Overview:
Parses the BLE UART module's reply to the AT+BLEUARTRX / AT+BLEUARTTX commands that bluetooth_encoder produces. It consumes a received byte stream (one byte per rx_valid strobe from the UART receiver) and extracts up to 4 payload bytes. It classifies the reply as OK, ERROR or timeout. It sits between the UART RX path and the controller that sequences bluetooth_encoder commands.

Parameters:
TIMEOUT_CYCLES, 1000000, clk cycles with no received byte, while busy, before the transaction is aborted with timeout.
TO_W, 20, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  arm the decoder for one reply; sampled only in IDLE
rx_byte  input  8  received ASCII byte
rx_valid  input  1  rx_byte valid this cycle; single-cycle strobe per byte
output_data  output  32  payload; first received byte in [7:0], second in [15:8], and so on; unused bytes 0
data_len  output  3  number of valid payload bytes, 0..4
done  output  1  1 = idle/result valid; 0 = transaction in progress
ok  output  1  reply terminated by line "OK"
error  output  1  reply terminated by line "ERROR"
timeout  output  1  aborted by inactivity
overflow  output  1  payload line longer than 4 bytes, or more than one payload line received

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, done=1, output_data=0, data_len=0, ok=error=timeout=overflow=0, line buffer and counters cleared. Reset asserted mid-transaction aborts it with no flag set.
- States:
  - IDLE: done=1. rx_valid is ignored. On start, clear output_data, data_len, all flags, line buffer, line_len, got_payload and timeout counter, then go to BUSY. done=0 from the next cycle. A byte arriving in the same cycle as start is dropped.
  - BUSY: done=0. start is ignored.
- Line collection, per accepted byte in BUSY:
  - CR (0x0D): discarded.
  - LF (0x0A): ends the line and triggers evaluation in the same cycle.
  - Any other byte: the first 5 bytes of the line are stored in the line buffer in arrival order. line_len increments and saturates at 7.
- Line evaluation on LF:
  - line_len=0: ignored.
  - Line equals "OK" (len 2): ok=1, go to IDLE. done=1 on the cycle after the LF edge.
  - Line equals "ERROR" (len 5): error=1, go to IDLE, same timing as OK.
  - Any other line, first such line: output_data gets the first min(len,4) bytes; data_len=min(len,4); overflow=1 if len>4; got_payload=1.
  - Any other line when got_payload=1: discarded and overflow=1.
  - line_len and the line buffer clear after every LF.
- A payload that is literally "OK" or "ERROR" is indistinguishable from the terminator. This is an accepted protocol limitation.
- Timeout:
  - The counter clears on start and on every accepted byte, and increments on each BUSY cycle with no byte.
  - If the counter equals TIMEOUT_CYCLES-1 and no byte is present, set timeout=1 and go to IDLE.
  - Result: done rises TIMEOUT_CYCLES cycles after the last byte edge (or after the start edge).
  - Payload captured before the timeout is retained.
- Result outputs hold until the next accepted start or reset.
- There is no backpressure. Every rx_valid byte in BUSY is consumed in one cycle, including back-to-back strobes.

Test Plan:
1. Payload reply: start, then bytes "ABCD\r\nOK\r\n" on consecutive cycles. Required: done=1 one cycle after the final LF; ok=1, error=0, output_data=32'h44434241, data_len=4, overflow=0.
2. Empty reply: start, then "OK\r\n". Required: ok=1, data_len=0, output_data=0.
3. Error reply: start, then "ERROR\r\n". Required: error=1, ok=0, data_len=0.
4. Long payload: start, then "HELLOWORLD\r\nOK\r\n". Required: output_data=32'h4C4C4548, data_len=4, overflow=1, ok=1. Repeat with "AB\r\nCD\r\nOK\r\n"; required: output_data=32'h00004241, data_len=2, overflow=1.
5. Timeout: TIMEOUT_CYCLES=16, start, send "AB", then idle. Required: done=1 and timeout=1 exactly 16 cycles after the 'B' edge; data_len=0; ok=error=0. Bytes sent afterwards in IDLE leave all outputs unchanged.
6. Reset and ignored start: pulse start again during BUSY, then drop reset_n mid-line. Required: the extra start has no effect; on reset all outputs return to reset values immediately, without a clock. A subsequent start followed by "Z\r\nOK\r\n" gives output_data=32'h0000005A, data_len=1, ok=1.
